clk_div_cfg_ctrl: RTL and testbench

//  Upstream configuration sequencer for the integer clock divider.

---
 rtl/clk_div_cfg_pkg.sv | 19 +
 rtl/clk_div_settle_cnt.sv | 39 +++
 rtl/clk_div_cfg_ctrl.sv | 138 +++++++++++++
 tb/tb_clk_div_cfg_ctrl.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_cfg_pkg.sv
// Shared definitions for the clock-divider configuration sequencer and its benches.
package clk_div_cfg_pkg;

    // Sequencer states: wait for a request, hold the divider disabled, let the new ratio settle.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SETTLE = 2'd2
    } cfg_state_e;

    // Ratio driven out of reset; 1 puts the divider in bypass.
    localparam int DIV_DEFAULT_RATIO = 1;

    // Width of a counter that must be able to represent the value n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/clk_div_settle_cnt.sv
// Up-counter with synchronous clear and a terminal-count flag; times DRAIN and SETTLE.
module clk_div_settle_cnt #(
    parameter int WIDTH    = 3,
    parameter int TERMINAL = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic o_tc
);

    localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Clear wins over count so the owner can restart the interval on the terminal edge.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/clk_div_cfg_ctrl.sv
// Configuration sequencer for the integer clock divider: never changes the ratio while
// the divider is enabled (drain, load, settle, re-enable) and rejects a zero ratio.
module clk_div_cfg_ctrl
    import clk_div_cfg_pkg::*;
#(
    parameter int RATIO_WIDTH   = 8,
    parameter int SETTLE_CYCLES = 4,
    parameter int DEFAULT_RATIO = DIV_DEFAULT_RATIO
) (
    input  logic                   i_ref_clk,
    input  logic                   i_rst,
    input  logic                   i_req_valid,
    output logic                   o_req_ready,
    input  logic [RATIO_WIDTH-1:0] i_req_ratio,
    input  logic                   i_req_enable,
    output logic [RATIO_WIDTH-1:0] o_div_ratio,
    output logic                   o_clk_en,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_cfg_err
);

    localparam int                     CNT_W     = cnt_width(SETTLE_CYCLES);
    localparam logic [RATIO_WIDTH-1:0] RST_RATIO = RATIO_WIDTH'(DEFAULT_RATIO);

    cfg_state_e             state_q, state_d;
    logic [RATIO_WIDTH-1:0] ratio_cap_q, ratio_cap_d;
    logic                   en_cap_q, en_cap_d;
    logic [RATIO_WIDTH-1:0] div_ratio_q, div_ratio_d;
    logic                   clk_en_q, clk_en_d;
    logic                   done_q, done_d;
    logic                   cfg_err_q, cfg_err_d;

    logic accept;
    logic cnt_clr;
    logic cnt_en;
    logic cnt_tc;

    assign accept = i_req_valid && (state_q == ST_IDLE);

    // The counter idles at zero and restarts at the end of each timed interval.
    assign cnt_clr = (state_q == ST_IDLE) || cnt_tc;
    assign cnt_en  = (state_q != ST_IDLE);

    clk_div_settle_cnt #(
        .WIDTH    (CNT_W),
        .TERMINAL (SETTLE_CYCLES - 1)
    ) u_settle_cnt (
        .clk  (i_ref_clk),
        .rst  (i_rst),
        .clr  (cnt_clr),
        .en   (cnt_en),
        .o_tc (cnt_tc)
    );

    // Next-state and output decisions; pulses default low, everything else holds.
    always_comb begin
        state_d     = state_q;
        ratio_cap_d = ratio_cap_q;
        en_cap_d    = en_cap_q;
        div_ratio_d = div_ratio_q;
        clk_en_d    = clk_en_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (i_req_ratio == '0) begin
                        cfg_err_d = 1'b1;
                    end else if ((i_req_ratio == div_ratio_q) && (i_req_enable == clk_en_q)) begin
                        // Nothing would change: complete without touching the divider.
                        done_d = 1'b1;
                    end else begin
                        ratio_cap_d = i_req_ratio;
                        en_cap_d    = i_req_enable;
                        if (clk_en_q) begin
                            clk_en_d = 1'b0;
                            state_d  = ST_DRAIN;
                        end else begin
                            // Already stopped, so the ratio can move immediately.
                            div_ratio_d = i_req_ratio;
                            state_d     = ST_SETTLE;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                if (cnt_tc) begin
                    div_ratio_d = ratio_cap_q;
                    state_d     = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_tc) begin
                    clk_en_d = en_cap_q;
                    done_d   = 1'b1;
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                clk_en_d = 1'b0;
            end
        endcase
    end

    // Control and output registers; reset drops any in-flight request.
    always_ff @(posedge i_ref_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            div_ratio_q <= RST_RATIO;
            clk_en_q    <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_ratio_q <= div_ratio_d;
            clk_en_q    <= clk_en_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // Captured request; only consumed after being written on an accept, so no reset needed.
    always_ff @(posedge i_ref_clk) begin
        ratio_cap_q <= ratio_cap_d;
        en_cap_q    <= en_cap_d;
    end

    assign o_req_ready = (state_q == ST_IDLE);
    assign o_busy      = (state_q != ST_IDLE);
    assign o_div_ratio = div_ratio_q;
    assign o_clk_en    = clk_en_q;
    assign o_done      = done_q;
    assign o_cfg_err   = cfg_err_q;

endmodule

// File: tb/tb_clk_div_cfg_ctrl.sv
// Bench for clk_div_cfg_ctrl with a small downstream divider model.
module tb_clk_div_cfg_ctrl;

    localparam int RW = 8;
    localparam int S  = 4;

    logic          clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_req_valid = 1'b0;
    logic [RW-1:0] i_req_ratio = '0;
    logic          i_req_enable = 1'b0;
    logic          o_req_ready;
    logic [RW-1:0] o_div_ratio;
    logic          o_clk_en;
    logic          o_busy;
    logic          o_done;
    logic          o_cfg_err;

    always #5 clk = ~clk;

    clk_div_cfg_ctrl #(
        .RATIO_WIDTH   (RW),
        .SETTLE_CYCLES (S),
        .DEFAULT_RATIO (1)
    ) dut (
        .i_ref_clk    (clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_ratio  (i_req_ratio),
        .i_req_enable (i_req_enable),
        .o_div_ratio  (o_div_ratio),
        .o_clk_en     (o_clk_en),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_cfg_err    (o_cfg_err)
    );

    // Downstream divider model: one output tick every o_div_ratio reference cycles.
    logic [RW-1:0] dcnt = '0;
    logic          div_pulse;
    always @(posedge clk) begin
        if (!o_clk_en) dcnt <= '0;
        else if (dcnt == o_div_ratio - 8'd1) dcnt <= '0;
        else dcnt <= dcnt + 8'd1;
    end
    assign div_pulse = o_clk_en && (dcnt == o_div_ratio - 8'd1);

    typedef struct {
        bit            is_err;
        logic [RW-1:0] ratio;
        logic          en;
    } exp_t;

    exp_t          sb_q[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    logic [RW-1:0] cur_ratio = 8'h01;
    logic          cur_en    = 1'b0;
    bit            armed     = 1'b0;

    // Scoreboard: every completion/reject pulse must match the oldest expected result.
    always @(negedge clk) begin
        exp_t x;
        if (!i_rst && (o_done || o_cfg_err)) begin
            n_tests++;
            if (o_done && o_cfg_err) begin
                n_fail++;
                $display("FAIL pulse_excl: done=%0b err=%0b, required not both", o_done, o_cfg_err);
            end else if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_empty: pulse done=%0b err=%0b with no expected entry", o_done, o_cfg_err);
            end else begin
                x = sb_q.pop_front();
                if (o_cfg_err !== x.is_err || o_div_ratio !== x.ratio || o_clk_en !== x.en) begin
                    n_fail++;
                    $display("FAIL sb_result: err=%0b ratio=%h en=%0b, required err=%0b ratio=%h en=%0b",
                             o_cfg_err, o_div_ratio, o_clk_en, x.is_err, x.ratio, x.en);
                end
            end
        end
    end

    // Ratio must never move while the divider is (or was, the cycle before) enabled.
    logic [RW-1:0] prev_ratio = '0;
    logic          prev_en    = 1'b0;
    always @(negedge clk) begin
        if (armed && !i_rst && (o_div_ratio !== prev_ratio)) begin
            n_tests++;
            if (prev_en || o_clk_en) begin
                n_fail++;
                $display("FAIL ratio_while_en: ratio %h->%h with en %0b->%0b, required en 0",
                         prev_ratio, o_div_ratio, prev_en, o_clk_en);
            end
        end
        prev_ratio <= o_div_ratio;
        prev_en    <= o_clk_en;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request and record what its completion must look like.
    task automatic drive_req(input logic [RW-1:0] r, input logic e);
        exp_t x;
        if (r == '0) begin
            x.is_err = 1'b1; x.ratio = cur_ratio; x.en = cur_en;
        end else begin
            x.is_err = 1'b0; x.ratio = r; x.en = e;
            cur_ratio = r; cur_en = e;
        end
        sb_q.push_back(x);
        i_req_valid  = 1'b1;
        i_req_ratio  = r;
        i_req_enable = e;
    endtask

    task automatic send(input logic [RW-1:0] r, input logic e);
        drive_req(r, e);
        tick();
        i_req_valid = 1'b0;
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        tick(); tick();
        i_rst = 1'b0;
        tick();
        armed = 1'b1;
        n_tests++;
        if (o_div_ratio !== 8'h01 || o_clk_en !== 1'b0 || o_req_ready !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: ratio=%h en=%0b ready=%0b busy=%0b, required 01/0/1/0",
                     o_div_ratio, o_clk_en, o_req_ready, o_busy);
        end
        n_tests++;
        if (o_done !== 1'b0 || o_cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pulses: done=%0b err=%0b, required 0/0", o_done, o_cfg_err);
        end
    endtask

    task automatic test_enable_from_disabled();
        time t0, t1;
        int  seen;
        send(8'h20, 1'b1);
        n_tests++;
        if (o_div_ratio !== 8'h20 || o_clk_en !== 1'b0 || o_busy !== 1'b1 || o_req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL en_dis_at_N: ratio=%h en=%0b busy=%0b ready=%0b, required 20/0/1/0",
                     o_div_ratio, o_clk_en, o_busy, o_req_ready);
        end
        for (int k = 1; k < S; k++) begin
            tick();
            n_tests++;
            if (o_clk_en !== 1'b0 || o_done !== 1'b0) begin
                n_fail++;
                $display("FAIL en_dis_settle k=%0d: en=%0b done=%0b, required 0/0", k, o_clk_en, o_done);
            end
        end
        tick();
        n_tests++;
        if (o_clk_en !== 1'b1 || o_done !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL en_dis_at_N+S: en=%0b done=%0b busy=%0b, required 1/1/0", o_clk_en, o_done, o_busy);
        end
        tick();
        n_tests++;
        if (o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL en_dis_done_width: done=%0b, required 0", o_done);
        end
        seen = 0; t0 = 0; t1 = 0;
        for (int c = 0; c < 200 && seen < 2; c++) begin
            if (div_pulse) begin
                if (seen == 0) t0 = $time; else t1 = $time;
                seen++;
            end
            tick();
        end
        n_tests++;
        if (seen < 2) begin
            n_fail++;
            $display("FAIL div_period: timeout, %0d ticks seen, required 2", seen);
        end else if (t1 - t0 != 320) begin
            n_fail++;
            $display("FAIL div_period: %0t, required 320 ns", t1 - t0);
        end
    endtask

    task automatic test_enabled_change();
        send(8'h08, 1'b1);
        n_tests++;
        if (o_clk_en !== 1'b0 || o_div_ratio !== 8'h20 || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL chg_at_N: en=%0b ratio=%h busy=%0b, required 0/20/1", o_clk_en, o_div_ratio, o_busy);
        end
        for (int k = 1; k <= 2 * S; k++) begin
            logic [RW-1:0] er;
            logic          ee;
            tick();
            er = (k < S) ? 8'h20 : 8'h08;
            ee = (k == 2 * S);
            n_tests++;
            if (o_div_ratio !== er || o_clk_en !== ee || o_done !== ee) begin
                n_fail++;
                $display("FAIL chg_seq k=%0d: ratio=%h en=%0b done=%0b, required %h/%0b/%0b",
                         k, o_div_ratio, o_clk_en, o_done, er, ee, ee);
            end
        end
        tick();
        n_tests++;
        if (o_done !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL chg_after: done=%0b busy=%0b, required 0/0", o_done, o_busy);
        end
    endtask

    task automatic test_cfg_err();
        send(8'h00, 1'b1);
        n_tests++;
        if (o_cfg_err !== 1'b1 || o_div_ratio !== 8'h08 || o_clk_en !== 1'b1 || o_req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL err_at_N: err=%0b ratio=%h en=%0b ready=%0b, required 1/08/1/1",
                     o_cfg_err, o_div_ratio, o_clk_en, o_req_ready);
        end
        tick();
        n_tests++;
        if (o_cfg_err !== 1'b0 || o_req_ready !== 1'b1 || o_div_ratio !== 8'h08) begin
            n_fail++;
            $display("FAIL err_width: err=%0b ready=%0b ratio=%h, required 0/1/08", o_cfg_err, o_req_ready, o_div_ratio);
        end
    endtask

    task automatic test_fast_path();
        send(8'h08, 1'b1);
        n_tests++;
        if (o_done !== 1'b1 || o_busy !== 1'b0 || o_clk_en !== 1'b1) begin
            n_fail++;
            $display("FAIL fast_at_N: done=%0b busy=%0b en=%0b, required 1/0/1", o_done, o_busy, o_clk_en);
        end
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_tests++;
            if (o_clk_en !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
                n_fail++;
                $display("FAIL fast_hold k=%0d: en=%0b busy=%0b done=%0b, required 1/0/0", k, o_clk_en, o_busy, o_done);
            end
        end
    endtask

    task automatic test_busy_reset();
        drive_req(8'h40, 1'b1);
        tick();
        // Keep valid asserted with a different ratio; it must not be taken while busy.
        i_req_ratio = 8'h10;
        n_tests++;
        if (o_busy !== 1'b1 || o_clk_en !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_at_N: busy=%0b en=%0b, required 1/0", o_busy, o_clk_en);
        end
        for (int k = 1; k <= S + 1; k++) begin
            tick();
            n_tests++;
            if (o_req_ready !== 1'b0 || o_busy !== 1'b1) begin
                n_fail++;
                $display("FAIL busy_ready k=%0d: ready=%0b busy=%0b, required 0/1", k, o_req_ready, o_busy);
            end
        end
        n_tests++;
        if (o_div_ratio !== 8'h40) begin
            n_fail++;
            $display("FAIL busy_no_reaccept: ratio=%h, required 40", o_div_ratio);
        end
        i_rst = 1'b1;
        sb_q.delete();
        tick();
        n_tests++;
        if (o_div_ratio !== 8'h01 || o_clk_en !== 1'b0 || o_busy !== 1'b0 || o_req_ready !== 1'b1
            || o_done !== 1'b0 || o_cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: ratio=%h en=%0b busy=%0b ready=%0b done=%0b err=%0b, required 01/0/0/1/0/0",
                     o_div_ratio, o_clk_en, o_busy, o_req_ready, o_done, o_cfg_err);
        end
        i_req_valid = 1'b0;
        i_rst = 1'b0;
        cur_ratio = 8'h01;
        cur_en = 1'b0;
        tick();
    endtask

    task automatic test_disable();
        send(8'h03, 1'b1);
        repeat (S) tick();
        n_tests++;
        if (o_clk_en !== 1'b1 || o_div_ratio !== 8'h03) begin
            n_fail++;
            $display("FAIL dis_setup: en=%0b ratio=%h, required 1/03", o_clk_en, o_div_ratio);
        end
        tick();
        send(8'h05, 1'b0);
        repeat (2 * S) tick();
        n_tests++;
        if (o_done !== 1'b1 || o_clk_en !== 1'b0 || o_div_ratio !== 8'h05 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL dis_end: done=%0b en=%0b ratio=%h busy=%0b, required 1/0/05/0",
                     o_done, o_clk_en, o_div_ratio, o_busy);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_enable_from_disabled();
        test_enabled_change();
        test_cfg_err();
        test_fast_path();
        test_busy_reset();
        test_disable();
        tick(); tick();
        n_tests++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: %0d entries pending, required 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
